// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one memory port between fetch (IF) and memory stage (DM).
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests instead of DM-first priority.
module mem_port_arbiter #(
  parameter int DEPTH   = 128,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [63:0]              if_addr,
  output logic [63:0]              if_rdata,
  output logic                     if_valid,
  output logic                     if_err,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [63:0]              dm_addr,
  input  logic [63:0]              dm_wdata,
  output logic [63:0]              dm_rdata,
  output logic                     dm_valid,
  output logic                     dm_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [63:0]              mem_wdata,
  input  logic [63:0]              mem_rdata,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic        owner_dm;
  logic        we_q;
  logic        grant_dm;
  logic [63:0] sel_addr;
  logic        addr_err;

`ifdef MEM_ARB_RR_EN
  logic last_dm;

  assign grant_dm = dm_req && (!if_req || !last_dm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_dm <= 1'b0;
    else if (state == IDLE && (dm_req || if_req))
      last_dm <= grant_dm;
  end
`else
  assign grant_dm = dm_req;
`endif

  assign sel_addr = grant_dm ? dm_addr : if_addr;
  // Full 64-bit compare so any set bit above the index range is an error.
  assign addr_err = (sel_addr >= 64'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 4'd0;
      owner_dm  <= 1'b0;
      we_q      <= 1'b0;
      if_rdata  <= 64'd0;
      if_valid  <= 1'b0;
      if_err    <= 1'b0;
      dm_rdata  <= 64'd0;
      dm_valid  <= 1'b0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 64'd0;
      busy      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      dm_valid <= 1'b0;
      dm_err   <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req || if_req) begin
            owner_dm  <= grant_dm;
            we_q      <= grant_dm && dm_we;
            mem_addr  <= sel_addr[AW-1:0];
            mem_wdata <= grant_dm ? dm_wdata : 64'd0;
            if (addr_err) begin
              // Error answers straight from IDLE so the pulse lands one cycle after the request.
              if (grant_dm) begin
                dm_valid <= 1'b1;
                dm_err   <= 1'b1;
                dm_rdata <= 64'd0;
              end else begin
                if_valid <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= 64'd0;
              end
            end else begin
              state  <= ACCESS;
              mem_en <= 1'b1;
              mem_we <= grant_dm && dm_we;
              busy   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          lat_cnt <= 4'(MEM_LAT - 1);
          state   <= (MEM_LAT > 1) ? WAIT : RESP;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1)
            state <= RESP;
        end
        RESP: begin
          if (owner_dm) begin
            dm_valid <= 1'b1;
            dm_rdata <= we_q ? 64'd0 : mem_rdata;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Directed bench: a MEM_LAT=1 instance (a_*) and a MEM_LAT=4 instance (b_*) driven by shared stimulus.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [63:0] if_addr = 64'd0, dm_addr = 64'd0, dm_wdata = 64'd0;

  logic [63:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_if_valid, a_if_err, a_dm_valid, a_dm_err, a_mem_en, a_mem_we, a_busy;
  logic [6:0]  a_mem_addr;
  logic [63:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_if_valid, b_if_err, b_dm_valid, b_dm_err, b_mem_en, b_mem_we, b_busy;
  logic [6:0]  b_mem_addr;

  logic [63:0] mem_a [128];
  logic [63:0] mem_b [128];
  logic [63:0] pipe_b [4];

  int n_checks = 0, n_fail = 0;
  int lat, ens, busy_n, stray;
  bit got_dm, got_if, en_we;
  logic [6:0] en_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(128), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid), .if_err(a_if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_valid(a_dm_valid), .dm_err(a_dm_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.DEPTH(128), .MEM_LAT(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid), .if_err(b_if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .dm_err(b_dm_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: data appears exactly MEM_LAT cycles after mem_en, garbage otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) begin
        mem_a[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
        mem_b[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
      end
    end else begin
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    end
  end

  always @(posedge clk) begin
    a_mem_rdata <= a_mem_en ? mem_a[a_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    pipe_b[0]   <= b_mem_en ? mem_b[b_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    pipe_b[1]   <= pipe_b[0];
    pipe_b[2]   <= pipe_b[1];
    pipe_b[3]   <= pipe_b[2];
  end
  assign b_mem_rdata = pipe_b[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for a completion pulse on the selected instance; lat counts cycles after the request cycle.
  task automatic wait_done(input bit slow);
    lat = 0; ens = 0; busy_n = 0; got_dm = 0; got_if = 0; en_we = 0; en_addr = '0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (slow ? b_busy : a_busy) busy_n++;
      if (slow ? b_mem_en : a_mem_en) begin
        ens++;
        en_we   = slow ? b_mem_we : a_mem_we;
        en_addr = slow ? b_mem_addr : a_mem_addr;
      end
      got_dm |= slow ? b_dm_valid : a_dm_valid;
      got_if |= slow ? b_if_valid : a_if_valid;
      if (got_dm || got_if) lat = n;
    end
    if (lat == 0) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic dm_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input bit slow);
    dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
    wait_done(slow);
    dm_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_mem_en", 64'(a_mem_en), 64'd0);
    check("rst_dm_valid", 64'(a_dm_valid), 64'd0);
    check("rst_if_valid", 64'(a_if_valid), 64'd0);
    check("rst_dm_rdata", a_dm_rdata, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // DM write then read back
    dm_access(1'b1, 64'd5, 64'hDEAD_BEEF, 1'b0);
    check("t1_wr_lat", 64'(lat), 64'd3);
    check("t1_wr_en", 64'(ens), 64'd1);
    check("t1_wr_we", 64'(en_we), 64'd1);
    check("t1_wr_addr", 64'(en_addr), 64'd5);
    check("t1_wr_err", 64'(a_dm_err), 64'd0);
    dm_access(1'b0, 64'd5, 64'd0, 1'b0);
    check("t1_rd_lat", 64'(lat), 64'd3);
    check("t1_rd_data", a_dm_rdata, 64'hDEAD_BEEF);

    // IF alone
    if_addr = 64'd0; if_req = 1'b1;
    wait_done(1'b0);
    if_req = 1'b0;
    check("t2_lat", 64'(lat), 64'd3);
    check("t2_en", 64'(ens), 64'd1);
    check("t2_we", 64'(en_we), 64'd0);
    check("t2_addr", 64'(en_addr), 64'd0);
    check("t2_dm_valid", 64'(got_dm), 64'd0);
    check("t2_rdata", a_if_rdata, 64'hA5A5_0000_0000_0000);

    // Simultaneous requests
    if_addr = 64'd1; dm_we = 1'b0; dm_addr = 64'd5; if_req = 1'b1; dm_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0);
      check("t3_rr_dm", 64'(got_dm), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("t3_rr_lat", 64'(lat), 64'd3);
    end
    dm_req = 1'b0; if_req = 1'b0;
`else
    wait_done(1'b0);
    check("t3_first_dm", 64'(got_dm), 64'd1);
    check("t3_first_if", 64'(got_if), 64'd0);
    dm_req = 1'b0;
    wait_done(1'b0);
    if_req = 1'b0;
    check("t3_second_if", 64'(got_if), 64'd1);
    check("t3_second_lat", 64'(lat), 64'd3);
`endif
    check("t3_if_rdata", a_if_rdata, 64'hA5A5_0000_0000_0001);

    // Address range errors and the last legal word
    dm_access(1'b0, 64'd128, 64'd0, 1'b0);
    check("t4_128_lat", 64'(lat), 64'd1);
    check("t4_128_en", 64'(ens), 64'd0);
    check("t4_128_err", 64'(a_dm_err), 64'd1);
    check("t4_128_rdata", a_dm_rdata, 64'd0);
    dm_access(1'b0, 64'd127, 64'd0, 1'b0);
    check("t4_127_lat", 64'(lat), 64'd3);
    check("t4_127_err", 64'(a_dm_err), 64'd0);
    check("t4_127_rdata", a_dm_rdata, 64'hA5A5_0000_0000_007F);
    dm_access(1'b0, 64'h1_0000_0000_0005, 64'd0, 1'b0);
    check("t4_hi_lat", 64'(lat), 64'd1);
    check("t4_hi_err", 64'(a_dm_err), 64'd1);
    check("t4_hi_rdata", a_dm_rdata, 64'd0);

    // MEM_LAT=4 instance
    repeat (12) @(negedge clk);
    dm_access(1'b0, 64'd7, 64'd0, 1'b1);
    check("t5_lat", 64'(lat), 64'd6);
    check("t5_busy", 64'(busy_n), 64'd5);
    check("t5_rdata", b_dm_rdata, 64'hA5A5_0000_0000_0007);

    // Reset in WAIT kills the access
    dm_we = 1'b0; dm_addr = 64'd9; dm_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy_wait", 64'(b_busy), 64'd1);
    dm_req = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 64'(b_busy), 64'd0);
    check("t6_rst_rdata", b_dm_rdata, 64'd0);
    check("t6_rst_valid", 64'(b_dm_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_dm_valid) stray++;
    end
    check("t6_no_answer", 64'(stray), 64'd0);
    dm_access(1'b0, 64'd9, 64'd0, 1'b1);
    check("t6_lat", 64'(lat), 64'd6);
    check("t6_rdata", b_dm_rdata, 64'hA5A5_0000_0000_0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
